gpo_seq_core: RTL and testbench

- MMIO slot core that sequences a general-purpose output port through a programmed table of output patterns, each held for a programmed number of clock cycles.
- Software loads the pattern and duration tables, the idle value and the configuration, then issues start. The core steps the port with no further bus traffic.
- Sits in the I/O slot array beside the plain GPO cores and uses the same slot interface.

---
 rtl/gpo_seq_core_pkg.sv | 28 ++
 rtl/gpo_seq_core_if.sv | 16 +
 rtl/gpo_seq_core.sv | 172 +++++++++++++++++
 tb/tb_gpo_seq_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_seq_core_pkg.sv
// Shared types and constants for the GPO sequencer slot core: FSM state
// encoding, slot register addresses and bit positions inside those registers.
package gpo_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_CFG      = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_IDLE     = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_CLR      = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_IDX      = 5'd4;
  localparam logic [ADDR_W-1:0] ADDR_DUR_BASE = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_PAT_BASE = 5'd16;

  localparam int BIT_START    = 0;
  localparam int BIT_STOP     = 1;
  localparam int BIT_LOOP     = 0;
  localparam int BIT_LAST_LSB = 8;
  localparam int BIT_BUSY     = 0;
  localparam int BIT_DONE     = 1;

endpackage

// File: rtl/gpo_seq_core_if.sv
// Slot bus shared by the I/O slot cores: the bus master drives select,
// strobes, address and write data; the slot returns decoded read data.
interface gpo_seq_core_if;
  import gpo_seq_pkg::*;

  logic              cs;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output cs, write, read, addr, wr_data, input rd_data);
  modport slave  (input cs, write, read, addr, wr_data, output rd_data);

endinterface

// File: rtl/gpo_seq_core.sv
// GPO sequencer slot core: steps the output port through a table of patterns,
// each held for its programmed duration plus one cycle, then idles or loops.
module gpo_seq_core
  import gpo_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  gpo_seq_core_if.slave bus,
  output logic [W-1:0]  dout,
  output logic          done
);

  localparam int LI = $clog2(DEPTH);

  state_t          r_state;
  state_t          w_nextState;
  logic [LI-1:0]   r_idx;
  logic [LI-1:0]   w_nextIdx;
  logic [LI-1:0]   w_idxInc;
  logic [LI-1:0]   r_lastIdx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nextCnt;
  logic [CW-1:0]   r_curDur;
  logic [CW-1:0]   w_nextCurDur;
  logic [W-1:0]    r_curPat;
  logic [W-1:0]    w_nextCurPat;
  logic [W-1:0]    r_idle;
  logic            r_done;
  logic            w_nextDone;
  logic            r_loop;
  logic [CW-1:0]   r_dur [DEPTH];
  logic [W-1:0]    r_pat [DEPTH];
  logic            w_wr;
  logic            w_start;
  logic            w_stop;
  logic            w_clr;
  logic [DATA_W-1:0] w_rdData;
  logic            w_unused;

  assign w_wr     = bus.cs && bus.write;
  assign w_stop   = w_wr && (bus.addr == ADDR_CTRL) && bus.wr_data[BIT_STOP];
  assign w_start  = w_wr && (bus.addr == ADDR_CTRL) && bus.wr_data[BIT_START];
  assign w_clr    = w_wr && (bus.addr == ADDR_CLR);
  assign w_idxInc = r_idx + 1'b1;

  // The read strobe carries no side effects and the upper write-data bits
  // have no home in any register, so they are deliberately left unconsumed.
  assign w_unused = ^{bus.read, bus.wr_data};

  // Software-visible configuration and table registers, written over the slot bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_loop    <= 1'b0;
      r_lastIdx <= '0;
      r_idle    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dur[i] <= '0;
        r_pat[i] <= '0;
      end
    end else if (w_wr) begin
      if (bus.addr == ADDR_CFG) begin
        r_loop    <= bus.wr_data[BIT_LOOP];
        r_lastIdx <= bus.wr_data[BIT_LAST_LSB +: LI];
      end
      if (bus.addr == ADDR_IDLE) begin
        r_idle <= bus.wr_data[W-1:0];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.addr == ADDR_DUR_BASE + 5'(i)) r_dur[i] <= bus.wr_data[CW-1:0];
        if (bus.addr == ADDR_PAT_BASE + 5'(i)) r_pat[i] <= bus.wr_data[W-1:0];
      end
    end
  end

  // Sequencer state: FSM state, entry index, hold counter, latched entry and done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_curPat <= '0;
      r_curDur <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_idx    <= w_nextIdx;
      r_cnt    <= w_nextCnt;
      r_curPat <= w_nextCurPat;
      r_curDur <= w_nextCurDur;
      r_done   <= w_nextDone;
    end
  end

  // Next-state logic: count out the current hold, then advance, wrap or finish;
  // stop overrides start, and start restarts from entry 0 in either state.
  always_comb begin
    w_nextState  = r_state;
    w_nextIdx    = r_idx;
    w_nextCnt    = r_cnt;
    w_nextCurPat = r_curPat;
    w_nextCurDur = r_curDur;
    w_nextDone   = r_done;
    if (w_clr) w_nextDone = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_cnt != r_curDur) begin
          w_nextCnt = r_cnt + 1'b1;
        end else if (r_idx != r_lastIdx) begin
          w_nextIdx    = w_idxInc;
          w_nextCnt    = '0;
          w_nextCurPat = r_pat[w_idxInc];
          w_nextCurDur = r_dur[w_idxInc];
        end else if (r_loop) begin
          w_nextIdx    = '0;
          w_nextCnt    = '0;
          w_nextCurPat = r_pat[0];
          w_nextCurDur = r_dur[0];
        end else begin
          w_nextState = ST_IDLE;
          w_nextIdx   = '0;
          w_nextDone  = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (w_stop) begin
      w_nextState = ST_IDLE;
      w_nextIdx   = '0;
    end else if (w_start) begin
      w_nextState  = ST_RUN;
      w_nextIdx    = '0;
      w_nextCnt    = '0;
      w_nextCurPat = r_pat[0];
      w_nextCurDur = r_dur[0];
      w_nextDone   = 1'b0;
    end
  end

  assign dout = (r_state == ST_RUN) ? r_curPat : r_idle;
  assign done = r_done;

  // Read-back mux: purely address-decoded, unmapped addresses return zero.
  always_comb begin
    w_rdData = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        w_rdData[BIT_BUSY] = (r_state == ST_RUN);
        w_rdData[BIT_DONE] = r_done;
      end
      ADDR_CFG: begin
        w_rdData[BIT_LOOP]            = r_loop;
        w_rdData[BIT_LAST_LSB +: LI]  = r_lastIdx;
      end
      ADDR_IDLE: w_rdData[W-1:0]  = r_idle;
      ADDR_IDX:  w_rdData[LI-1:0] = r_idx;
      default: begin
      end
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.addr == ADDR_DUR_BASE + 5'(i)) w_rdData[CW-1:0] = r_dur[i];
      if (bus.addr == ADDR_PAT_BASE + 5'(i)) w_rdData[W-1:0]  = r_pat[i];
    end
  end

  assign bus.rd_data = w_rdData;

endmodule

// File: tb/tb_gpo_seq_core.sv
// Self-checking bench for the GPO sequencer: directed scenarios plus
// randomized tables compared against a period-based reference model.
module tb_gpo_seq_core;
  import gpo_seq_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dout;
  logic         done;

  gpo_seq_core_if bus();

  gpo_seq_core #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dout  (dout),
    .done  (done)
  );

  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model of the programmed table, as software sees it
  logic [W-1:0] mPat [DEPTH];
  int           mDur [DEPTH];
  int           mLast;
  bit           mLoop;
  logic [W-1:0] mIdle;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic busRead(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd_data;
  endtask

  task automatic stepCycle();
    @(posedge clk); #1;
  endtask

  // Length in cycles of one pass through entries 0..mLast
  function automatic int period();
    int p;
    p = 0;
    for (int i = 0; i <= mLast; i++) p += mDur[i] + 1;
    return p;
  endfunction

  // Expected port value k cycles after the start edge
  function automatic logic [W-1:0] expDout(input int k);
    int p;
    int t;
    p = period();
    if (!mLoop && k >= p) return mIdle;
    t = k % p;
    for (int i = 0; i <= mLast; i++) begin
      if (t <= mDur[i]) return mPat[i];
      t -= mDur[i] + 1;
    end
    return mIdle;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < DEPTH; i++) begin
      busWrite(ADDR_PAT_BASE + 5'(i), 32'(mPat[i]));
      busWrite(ADDR_DUR_BASE + 5'(i), 32'(mDur[i]));
    end
    busWrite(ADDR_CFG, {21'd0, 3'(mLast), 7'd0, mLoop});
    busWrite(ADDR_IDLE, 32'(mIdle));
  endtask

  // Issue start and compare the port against the model for n cycles
  task automatic runAndCheck(input int n, input string tag);
    busWrite(ADDR_CTRL, 32'h1);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s dout k=%0d", tag, k), 32'(dout), 32'(expDout(k)));
      stepCycle();
    end
  endtask

  logic [31:0] rd;
  logic [31:0] rnd;
  logic [7:0]  dirExp [8];

  initial begin
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.wr_data = '0;

    // Reset state
    reset = 1'b0;
    #1;
    checkOutput("reset dout", 32'(dout), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    stepCycle();
    for (int a = 0; a <= 4; a++) begin
      busRead(5'(a), rd);
      checkOutput($sformatf("reset rd addr%0d", a), rd, 32'h0);
    end
    busRead(ADDR_DUR_BASE, rd); checkOutput("reset rd DUR0", rd, 32'h0);
    busRead(ADDR_PAT_BASE, rd); checkOutput("reset rd PAT0", rd, 32'h0);

    // Directed one-shot sequence with hand-derived expectations
    for (int i = 0; i < DEPTH; i++) begin mPat[i] = '0; mDur[i] = 0; end
    mPat[0] = 8'h11; mPat[1] = 8'h22; mPat[2] = 8'h33;
    mDur[0] = 0;     mDur[1] = 2;     mDur[2] = 1;
    mLast = 2; mLoop = 1'b0; mIdle = 8'h00;
    dirExp = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00, 8'h00};
    stepCycle();
    applyStimulus();
    busWrite(ADDR_CTRL, 32'h1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("oneshot dout k=%0d", k), 32'(dout), 32'(dirExp[k]));
      stepCycle();
    end
    checkOutput("oneshot done", 32'(done), 32'h1);
    busRead(ADDR_CTRL, rd); checkOutput("oneshot STATUS", rd, 32'h2);
    busWrite(ADDR_CLR, 32'h0);
    checkOutput("clr done", 32'(done), 32'h0);
    busRead(ADDR_CTRL, rd); checkOutput("clr STATUS", rd, 32'h0);

    // Looping: three gapless periods, then stop in the middle of entry 1
    mLoop = 1'b1;
    busWrite(ADDR_CFG, 32'h0000_0201);
    runAndCheck(20, "loop");
    busWrite(ADDR_CTRL, 32'h2);
    checkOutput("stop dout", 32'(dout), 32'(mIdle));
    checkOutput("stop done", 32'(done), 32'h0);
    busRead(ADDR_IDX, rd);  checkOutput("stop IDX", rd, 32'h0);
    busRead(ADDR_CTRL, rd); checkOutput("stop STATUS", rd, 32'h0);

    // Start and stop together while idle: stop wins
    busWrite(ADDR_IDLE, 32'h5A); mIdle = 8'h5A;
    busWrite(ADDR_CTRL, 32'h3);
    busRead(ADDR_CTRL, rd); checkOutput("startstop STATUS", rd, 32'h0);
    checkOutput("startstop dout", 32'(dout), 32'h5A);

    // Restart while running at entry 2
    runAndCheck(5, "prerestart");
    checkOutput("prerestart entry2", 32'(dout), 32'h33);
    busWrite(ADDR_CTRL, 32'h1);
    checkOutput("restart dout", 32'(dout), 32'h11);
    busRead(ADDR_IDX, rd); checkOutput("restart IDX", rd, 32'h0);
    stepCycle();
    checkOutput("restart dout k1", 32'(dout), 32'h22);

    // Rewrite PAT[1] while entry 1 is being held
    busWrite(ADDR_CTRL, 32'h2);
    busWrite(ADDR_CTRL, 32'h1);
    stepCycle();
    checkOutput("rewrite k1", 32'(dout), 32'h22);
    busWrite(ADDR_PAT_BASE + 5'd1, 32'hAA);
    dirExp = '{8'h22, 8'h22, 8'h33, 8'h33, 8'h11, 8'hAA, 8'hAA, 8'hAA};
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rewrite dout k=%0d", k + 2), 32'(dout), 32'(dirExp[k]));
      stepCycle();
    end
    checkOutput("rewrite k10", 32'(dout), 32'h33);
    busWrite(ADDR_CTRL, 32'h2);

    // Randomized tables checked against the period model
    for (int trial = 0; trial < 15; trial++) begin
      rnd = $urandom;
      busWrite(ADDR_DUR_BASE + 5'(trial % DEPTH), rnd);
      busRead(ADDR_DUR_BASE + 5'(trial % DEPTH), rd);
      checkOutput($sformatf("t%0d DUR readback", trial), rd, rnd & 32'h00FF_FFFF);
      rnd = $urandom;
      busWrite(ADDR_PAT_BASE + 5'(trial % DEPTH), rnd);
      busRead(ADDR_PAT_BASE + 5'(trial % DEPTH), rd);
      checkOutput($sformatf("t%0d PAT readback", trial), rd, rnd & 32'h0000_00FF);
      for (int i = 0; i < DEPTH; i++) begin
        mPat[i] = W'($urandom);
        mDur[i] = int'($urandom_range(0, 3));
      end
      rnd   = $urandom;
      mLoop = rnd[0];
      mLast = int'(rnd[10:8]);
      mIdle = W'($urandom);
      applyStimulus();
      busRead(ADDR_IDLE, rd); checkOutput($sformatf("t%0d IDLE readback", trial), rd, 32'(mIdle));
      checkOutput($sformatf("t%0d idle dout", trial), 32'(dout), 32'(mIdle));
      if (mLoop) begin
        runAndCheck(2 * period() + 1, $sformatf("t%0d loop", trial));
        busWrite(ADDR_CTRL, 32'h2);
        checkOutput($sformatf("t%0d stop dout", trial), 32'(dout), 32'(mIdle));
        checkOutput($sformatf("t%0d stop done", trial), 32'(done), 32'h0);
        busRead(ADDR_IDX, rd); checkOutput($sformatf("t%0d stop IDX", trial), rd, 32'h0);
      end else begin
        runAndCheck(period() + 2, $sformatf("t%0d oneshot", trial));
        checkOutput($sformatf("t%0d done", trial), 32'(done), 32'h1);
        busRead(ADDR_CTRL, rd); checkOutput($sformatf("t%0d STATUS", trial), rd, 32'h2);
        busWrite(ADDR_CLR, 32'h0);
        checkOutput($sformatf("t%0d clr done", trial), 32'(done), 32'h0);
      end
    end

    // Reset in the middle of a looping run
    busWrite(ADDR_CFG, 32'h0000_0701);
    busWrite(ADDR_IDLE, 32'hC3);
    busWrite(ADDR_CTRL, 32'h1);
    repeat (3) stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("midreset dout", 32'(dout), 32'h0);
    checkOutput("midreset done", 32'(done), 32'h0);
    stepCycle();
    reset = 1'b1;
    stepCycle();
    busRead(ADDR_CTRL, rd); checkOutput("postreset STATUS", rd, 32'h0);
    busRead(ADDR_CFG, rd);  checkOutput("postreset CFG", rd, 32'h0);
    busRead(ADDR_IDLE, rd); checkOutput("postreset IDLE", rd, 32'h0);
    busRead(ADDR_IDX, rd);  checkOutput("postreset IDX", rd, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      busRead(ADDR_DUR_BASE + 5'(i), rd); checkOutput($sformatf("postreset DUR%0d", i), rd, 32'h0);
      busRead(ADDR_PAT_BASE + 5'(i), rd); checkOutput($sformatf("postreset PAT%0d", i), rd, 32'h0);
    end
    checkOutput("postreset dout", 32'(dout), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
